// File: rtl/crossbar_pkg.sv
// Shared types and helpers for the stream crossbar schedulers.
package crossbar_pkg;

  typedef enum logic {SCHED_IDLE, SCHED_XFER} sched_state_t;

  // Round-robin pointer after releasing master k out of n (wraps n-1 -> 0).
  function automatic int unsigned rr_next_ptr(input int unsigned k, input int unsigned n);
    if (n <= 1) begin
      return 0;
    end else if (k >= n - 1) begin
      return 0;
    end else begin
      return k + 1;
    end
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set bit of mask_i searching upward from start_i.
module rr_priority_picker #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic [N-1:0] mask_i,
  input  logic [W-1:0] start_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  always_comb begin
    int unsigned cand;
    cand    = 0;
    idx_o   = '0;
    found_o = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = (32'(start_i) + off) % N;
      if (!found_o && mask_i[cand]) begin
        found_o = 1'b1;
        idx_o   = W'(cand);
      end
    end
  end

endmodule

// File: rtl/stream_slave_port_scheduler.sv
// Per-slave-port packet scheduler: whole-packet grants, round-robin priority and idle timeout.
module stream_slave_port_scheduler
  import crossbar_pkg::*;
#(
  parameter  int unsigned S_DATA_COUNT   = 2,
  parameter  int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned T_ID_WIDTH     = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_in,
  input  logic [S_DATA_COUNT-1:0] requests_i,
  input  logic [S_DATA_COUNT-1:0] last_i,
  input  logic                    s_ready_i,
  output logic [S_DATA_COUNT-1:0] grant_o,
  output logic [T_ID_WIDTH-1:0]   id_o,
  output logic                    active_o,
  output logic                    pkt_done_o,
  output logic                    timeout_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  sched_state_t            r_state, w_state_next;
  logic [T_ID_WIDTH-1:0]   r_id, w_id_next;
  logic [S_DATA_COUNT-1:0] r_grant, w_grant_next;
  logic [T_ID_WIDTH-1:0]   r_ptr, w_ptr_next;
  logic [CNT_W-1:0]        r_idle_cnt, w_cnt_next;
  logic                    r_pkt_done, w_pkt_done_next;
  logic                    r_timeout, w_timeout_next;

  logic                    w_xfer;
  logic                    w_owner_valid;
  logic                    w_last;
  logic                    w_expire;
  logic [T_ID_WIDTH-1:0]   w_rel_ptr;
  logic [S_DATA_COUNT-1:0] w_pick_mask;
  logic [T_ID_WIDTH-1:0]   w_pick_start;
  logic [T_ID_WIDTH-1:0]   w_pick_idx;
  logic                    w_pick_found;

  assign w_xfer        = (r_state == SCHED_XFER);
  assign w_owner_valid = requests_i[r_id];
  assign w_last        = w_xfer & w_owner_valid & s_ready_i & last_i[r_id];
  // Idle only counts when the owner has no valid beat; a not-ready stall never expires.
  assign w_expire      = (TIMEOUT_CYCLES != 0) && w_xfer && !w_owner_valid &&
                         (r_idle_cnt == CNT_LAST);
  assign w_rel_ptr     = T_ID_WIDTH'(rr_next_ptr(32'(r_id), S_DATA_COUNT));

  // Handover excludes the outgoing owner and searches from the post-release pointer.
  assign w_pick_mask  = w_xfer ? (requests_i & ~r_grant) : requests_i;
  assign w_pick_start = w_xfer ? w_rel_ptr : r_ptr;

  rr_priority_picker #(
    .N (S_DATA_COUNT),
    .W (T_ID_WIDTH)
  ) u_picker (
    .mask_i  (w_pick_mask),
    .start_i (w_pick_start),
    .idx_o   (w_pick_idx),
    .found_o (w_pick_found)
  );

  always_comb begin
    w_state_next    = r_state;
    w_id_next       = r_id;
    w_grant_next    = r_grant;
    w_ptr_next      = r_ptr;
    w_cnt_next      = r_idle_cnt;
    w_pkt_done_next = 1'b0;
    w_timeout_next  = 1'b0;
    unique case (r_state)
      SCHED_IDLE: begin
        w_cnt_next = '0;
        if (w_pick_found) begin
          w_state_next = SCHED_XFER;
          w_id_next    = w_pick_idx;
          w_grant_next = S_DATA_COUNT'(1) << w_pick_idx;
        end
      end
      SCHED_XFER: begin
        if (w_last || w_expire) begin
          w_pkt_done_next = w_last;
          w_timeout_next  = w_expire & ~w_last;
          w_ptr_next      = w_rel_ptr;
          w_cnt_next      = '0;
          if (w_pick_found) begin
            w_id_next    = w_pick_idx;
            w_grant_next = S_DATA_COUNT'(1) << w_pick_idx;
          end else begin
            w_state_next = SCHED_IDLE;
            w_id_next    = '0;
            w_grant_next = '0;
          end
        end else if (w_owner_valid) begin
          w_cnt_next = '0;
        end else if (TIMEOUT_CYCLES != 0) begin
          w_cnt_next = r_idle_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = SCHED_IDLE;
        w_id_next    = '0;
        w_grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= SCHED_IDLE;
      r_id       <= '0;
      r_grant    <= '0;
      r_ptr      <= '0;
      r_idle_cnt <= '0;
      r_pkt_done <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_id       <= w_id_next;
      r_grant    <= w_grant_next;
      r_ptr      <= w_ptr_next;
      r_idle_cnt <= w_cnt_next;
      r_pkt_done <= w_pkt_done_next;
      r_timeout  <= w_timeout_next;
    end
  end

  assign grant_o    = r_grant;
  assign id_o       = r_id;
  assign active_o   = w_xfer;
  assign pkt_done_o = r_pkt_done;
  assign timeout_o  = r_timeout;

endmodule

// File: tb/tb_stream_slave_port_scheduler.sv
// Directed bench for stream_slave_port_scheduler with 4 masters and a 16-cycle timeout.
module tb_stream_slave_port_scheduler;

  localparam int unsigned N = 4;
  localparam int unsigned W = 2;

  logic         clk_i = 1'b0;
  logic         rst_in;
  logic [N-1:0] requests_i;
  logic [N-1:0] last_i;
  logic         s_ready_i;
  logic [N-1:0] grant_o;
  logic [W-1:0] id_o;
  logic         active_o;
  logic         pkt_done_o;
  logic         timeout_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned pulses;
  int unsigned tos;

  stream_slave_port_scheduler #(
    .S_DATA_COUNT   (N),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i      (clk_i),
    .rst_in     (rst_in),
    .requests_i (requests_i),
    .last_i     (last_i),
    .s_ready_i  (s_ready_i),
    .grant_o    (grant_o),
    .id_o       (id_o),
    .active_o   (active_o),
    .pkt_done_o (pkt_done_o),
    .timeout_o  (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return on the falling edge for sampling/driving.
  task automatic tick;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    rst_in     = 1'b0;
    requests_i = '0;
    last_i     = '0;
    s_ready_i  = 1'b1;
    repeat (2) tick;
    check_eq("rst_grant", 32'(grant_o), 32'h0);
    check_eq("rst_active", 32'(active_o), 32'h0);
    check_eq("rst_id", 32'(id_o), 32'h0);
    check_eq("rst_done", 32'(pkt_done_o), 32'h0);
    check_eq("rst_tmo", 32'(timeout_o), 32'h0);
    rst_in = 1'b1;

    // 1-cycle request to grant, then handover 1 -> 3
    requests_i = 4'b1010;
    tick;
    check_eq("t1_id", 32'(id_o), 32'd1);
    check_eq("t1_grant", 32'(grant_o), 32'b0010);
    check_eq("t1_active", 32'(active_o), 32'h1);
    last_i = 4'b1010;
    tick;
    check_eq("t1_done", 32'(pkt_done_o), 32'h1);
    check_eq("t1_hand_id", 32'(id_o), 32'd3);
    check_eq("t1_hand_grant", 32'(grant_o), 32'b1000);
    requests_i = 4'b1000;
    last_i     = 4'b1000;
    tick;
    check_eq("t1_idle_active", 32'(active_o), 32'h0);
    check_eq("t1_idle_grant", 32'(grant_o), 32'h0);
    check_eq("t1_done2", 32'(pkt_done_o), 32'h1);
    requests_i = '0;
    last_i     = '0;
    tick;
    check_eq("t1_done_clr", 32'(pkt_done_o), 32'h0);

    // All request, 3-beat packets: 0,1,2,3,0 with no idle gap
    requests_i = 4'b1111;
    tick;
    pulses = 0;
    for (int p = 0; p < 5; p++) begin
      check_eq("t2_id", 32'(id_o), 32'(p % 4));
      check_eq("t2_grant", 32'(grant_o), 32'(1) << (p % 4));
      for (int b = 0; b < 3; b++) begin
        last_i = (b == 2) ? 4'b1111 : 4'b0000;
        tick;
        check_eq("t2_active", 32'(active_o), 32'h1);
        pulses += 32'(pkt_done_o);
      end
    end
    check_eq("t2_pulses", pulses, 32'd5);
    check_eq("t2_after_id", 32'(id_o), 32'd1);
    requests_i = 4'b0010;
    last_i     = 4'b0010;
    tick;
    check_eq("t2_idle", 32'(active_o), 32'h0);
    requests_i = '0;
    last_i     = '0;
    tick;

    // Owner 2 bubbles for 5 cycles: grant held despite other requesters
    requests_i = 4'b0100;
    tick;
    check_eq("t3_id", 32'(id_o), 32'd2);
    tick;
    requests_i = 4'b1011;
    tos = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      check_eq("t3_hold", 32'(grant_o), 32'b0100);
      tos += 32'(timeout_o);
    end
    check_eq("t3_no_tmo", tos, 32'd0);
    requests_i = 4'b1111;
    last_i     = 4'b0100;
    tick;
    check_eq("t3_hand_id", 32'(id_o), 32'd3);
    check_eq("t3_done", 32'(pkt_done_o), 32'h1);
    requests_i = 4'b1010;
    last_i     = 4'b1000;
    tick;
    check_eq("t3_id1", 32'(id_o), 32'd1);
    check_eq("t3_grant1", 32'(grant_o), 32'b0010);

    // Owner 1 idle 16 cycles with master 3 waiting -> forced handover
    requests_i = 4'b1000;
    last_i     = '0;
    repeat (15) tick;
    check_eq("t4_pre_grant", 32'(grant_o), 32'b0010);
    check_eq("t4_pre_tmo", 32'(timeout_o), 32'h0);
    tick;
    check_eq("t4_tmo", 32'(timeout_o), 32'h1);
    check_eq("t4_done0", 32'(pkt_done_o), 32'h0);
    check_eq("t4_id", 32'(id_o), 32'd3);
    check_eq("t4_grant", 32'(grant_o), 32'b1000);
    last_i = 4'b1000;
    tick;
    check_eq("t4_tmo_clr", 32'(timeout_o), 32'h0);
    check_eq("t4_done", 32'(pkt_done_o), 32'h1);
    check_eq("t4_idle", 32'(active_o), 32'h0);
    requests_i = '0;
    last_i     = '0;
    tick;

    // Single requester back-to-back: one idle cycle between packets
    requests_i = 4'b0001;
    tick;
    check_eq("t5_active", 32'(active_o), 32'h1);
    check_eq("t5_id", 32'(id_o), 32'd0);
    last_i = 4'b0001;
    tick;
    check_eq("t5_done", 32'(pkt_done_o), 32'h1);
    check_eq("t5_gap", 32'(active_o), 32'h0);
    tick;
    check_eq("t5_regrant", 32'(active_o), 32'h1);
    check_eq("t5_regrant_id", 32'(id_o), 32'd0);
    tick;
    check_eq("t5_done2", 32'(pkt_done_o), 32'h1);
    check_eq("t5_gap2", 32'(active_o), 32'h0);
    requests_i = '0;
    last_i     = '0;
    tick;

    // Async reset mid-packet, then pointer back at 0
    requests_i = 4'b0100;
    tick;
    check_eq("t6_id", 32'(id_o), 32'd2);
    tick;
    #2 rst_in = 1'b0;
    #1;
    check_eq("t6_rst_grant", 32'(grant_o), 32'h0);
    check_eq("t6_rst_active", 32'(active_o), 32'h0);
    check_eq("t6_rst_id", 32'(id_o), 32'h0);
    @(negedge clk_i);
    rst_in     = 1'b1;
    requests_i = 4'b0011;
    tick;
    check_eq("t6_ptr_id", 32'(id_o), 32'd0);
    check_eq("t6_ptr_grant", 32'(grant_o), 32'b0001);

    // Owner valid but slave stalled: never a timeout
    s_ready_i = 1'b0;
    tos = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      tos += 32'(timeout_o);
    end
    check_eq("stall_no_tmo", tos, 32'd0);
    check_eq("stall_grant", 32'(grant_o), 32'b0001);
    s_ready_i = 1'b1;
    last_i    = 4'b0011;
    tick;
    check_eq("stall_hand_id", 32'(id_o), 32'd1);
    check_eq("stall_done", 32'(pkt_done_o), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
